// File: rtl/instr_decode.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_decode : one-entry decode/issue stage, scoreboard stall, HALT
// rev 1.0
// ------------------------------------------------------------------
module instr_decode (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_instr,
  output logic [1:0] reg1,
  output logic [1:0] reg2,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_op,
  output logic [1:0] out_rd,
  output logic       out_we,
  output logic [7:0] out_a,
  output logic [7:0] out_b,
  input  logic       wb_valid,
  input  logic [1:0] wb_reg,
  output logic [3:0] pending,
  output logic       halted
);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_FULL   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t     state_q;
  logic [8:0] ir_q;
  logic       out_valid_q;
  logic [2:0] out_op_q;
  logic [1:0] out_rd_q;
  logic       out_we_q;
  logic [7:0] out_a_q;
  logic [7:0] out_b_q;
  logic [3:0] pending_q;
  logic [3:0] pending_d;
  logic       halted_q;

  logic [2:0] ir_op;
  logic [1:0] ir_rd;
  logic [1:0] ir_rs1;
  logic [1:0] ir_rs2;
  logic       ir_alu;
  logic       ir_store;
  logic       ir_halt;
  logic [3:0] wb_mask;
  logic [3:0] eff;
  logic       hazard;
  logic       out_free;
  logic       issue;
  logic       retire;
  logic       accept;

  assign ir_op    = ir_q[8:6];
  assign ir_rd    = ir_q[5:4];
  assign ir_rs1   = ir_q[3:2];
  assign ir_rs2   = ir_q[1:0];
  assign ir_alu   = (ir_op <= 3'd5);
  assign ir_store = (ir_op == 3'd6);
  assign ir_halt  = (ir_op == 3'd7);

  // A writeback landing this cycle already frees its register for issue.
  assign wb_mask = wb_valid ? (4'b0001 << wb_reg) : 4'b0000;
  assign eff     = pending_q & ~wb_mask;

  assign hazard = (ir_alu   && (eff[ir_rs1] || eff[ir_rs2] || eff[ir_rd])) ||
                  (ir_store && (eff[ir_rs1] || eff[ir_rs2]));

  assign out_free = !out_valid_q || out_ready;
  assign issue    = (state_q == S_FULL) && !ir_halt && !hazard && out_free;
  assign retire   = (state_q == S_FULL) && ir_halt && (eff == 4'b0000) && !out_valid_q;
  assign in_ready = reset && ((state_q == S_EMPTY) || issue);
  assign accept   = in_valid && in_ready;

  // A new reservation beats a same-cycle writeback to the same register.
  assign pending_d = eff | ((issue && ir_alu) ? (4'b0001 << ir_rd) : 4'b0000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_EMPTY;
      ir_q        <= 9'd0;
      out_valid_q <= 1'b0;
      out_op_q    <= 3'd0;
      out_rd_q    <= 2'd0;
      out_we_q    <= 1'b0;
      out_a_q     <= 8'd0;
      out_b_q     <= 8'd0;
      pending_q   <= 4'd0;
      halted_q    <= 1'b0;
    end else begin
      if (accept) begin
        ir_q <= in_instr;
      end
      case (state_q)
        S_EMPTY:  if (accept) state_q <= S_FULL;
        S_FULL: begin
          if (retire) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end else if (issue && !accept) begin
            state_q <= S_EMPTY;
          end
        end
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_EMPTY;
      endcase
      if (issue) begin
        out_valid_q <= 1'b1;
        out_op_q    <= ir_op;
        out_rd_q    <= ir_rd;
        out_we_q    <= ir_alu;
        out_a_q     <= data1;
        out_b_q     <= data2;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      pending_q <= pending_d;
    end
  end

  assign reg1      = ir_rs1;
  assign reg2      = ir_rs2;
  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_rd    = out_rd_q;
  assign out_we    = out_we_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign pending   = pending_q;
  assign halted    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_instr_decode : directed self-checking bench for instr_decode
// rev 1.0
// ------------------------------------------------------------------
module tb_instr_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_instr;
  logic [1:0] reg1;
  logic [1:0] reg2;
  logic [7:0] data1;
  logic [7:0] data2;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_op;
  logic [1:0] out_rd;
  logic       out_we;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic       wb_valid;
  logic [1:0] wb_reg;
  logic [3:0] pending;
  logic       halted;

  logic [7:0] rf [4];
  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;

  always #5 clk = ~clk;

  assign data1 = rf[reg1];
  assign data2 = rf[reg2];

  always @(posedge clk) if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;

  instr_decode dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .reg1(reg1), .reg2(reg2), .data1(data1), .data2(data2),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rd(out_rd), .out_we(out_we), .out_a(out_a), .out_b(out_b),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .pending(pending), .halted(halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_instr  = 9'd0;
    out_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_reg    = 2'd0;
    reset     = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    in_valid  = 1'b1;
    in_instr  = 9'b000_01_10_11;
    out_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_reg    = 2'd0;
    reset     = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0h exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    checks++; if ({out_op, out_rd, out_we, out_a, out_b} !== 22'd0) begin failures++; $display("FAIL rst_payload got=%0h exp=0", {out_op, out_rd, out_we, out_a, out_b}); end
    checks++; if ({pending, halted, reg1, reg2} !== 9'd0) begin failures++; $display("FAIL rst_state got=%0h exp=0", {pending, halted, reg1, reg2}); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%0h exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_midop got=%0h exp=1", out_valid); end
    reset = 1'b0;
    #1;
    checks++; if ({out_valid, pending, reg1, reg2, out_a} !== 17'd0) begin failures++; $display("FAIL rst_midop got=%0h exp=0", {out_valid, pending, reg1, reg2, out_a}); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    in_valid = 1'b1;
    in_instr = 9'b000_01_10_11;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (reg1 !== 2'd2 || reg2 !== 2'd3) begin failures++; $display("FAIL basic_regs got=%0h/%0h exp=2/3", reg1, reg2); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0h exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_op !== 3'd0 || out_rd !== 2'd1 || out_we !== 1'b1) begin failures++; $display("FAIL basic_ctl got=%0h/%0h/%0h/%0h exp=1/0/1/1", out_valid, out_op, out_rd, out_we); end
    checks++; if (out_a !== 8'h05 || out_b !== 8'h07) begin failures++; $display("FAIL basic_data got=%0h/%0h exp=05/07", out_a, out_b); end
    checks++; if (pending !== 4'b0010) begin failures++; $display("FAIL basic_pending got=%0b exp=0010", pending); end
  endtask

  task automatic test_raw();
    do_reset();
    in_valid = 1'b1;
    in_instr = 9'b000_01_00_00;
    tick();
    in_instr = 9'b000_01_01_00;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_ready_issue got=%0h exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || pending !== 4'b0010) begin failures++; $display("FAIL raw_stall got=%0h/%0b exp=0/0010", in_ready, pending); end
    tick();
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL raw_held got=%0h/%0h exp=0/0", out_valid, in_ready); end
    wb_valid = 1'b1;
    wb_reg   = 2'd1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_bypass_ready got=%0h exp=1", in_ready); end
    tick();
    wb_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 2'd1 || pending !== 4'b0010) begin failures++; $display("FAIL raw_bypass_issue got=%0h/%0h/%0b exp=1/1/0010", out_valid, out_rd, pending); end
  endtask

  task automatic test_backpressure();
    do_reset();
    hs_cnt    = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 9'b000_00_10_11;
    tick();
    in_instr = 9'b001_11_10_10;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept2 got=%0h exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 2'd0 || pending !== 4'b0001) begin failures++; $display("FAIL bp_first got=%0h/%0h/%0b exp=1/0/0001", out_valid, out_rd, pending); end
    repeat (3) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_op !== 3'd0 || out_rd !== 2'd0 || out_a !== 8'h05 || out_b !== 8'h07) begin failures++; $display("FAIL bp_stable got=%0h/%0h/%0h/%0h/%0h exp=1/0/0/05/07", out_valid, out_op, out_rd, out_a, out_b); end
      checks++; if (in_ready !== 1'b0 || reg1 !== 2'd2 || reg2 !== 2'd2) begin failures++; $display("FAIL bp_ir_hold got=%0h/%0h/%0h exp=0/2/2", in_ready, reg1, reg2); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_op !== 3'd1 || out_rd !== 2'd3 || out_a !== 8'h05 || out_b !== 8'h05) begin failures++; $display("FAIL bp_second got=%0h/%0h/%0h/%0h/%0h exp=1/1/3/05/05", out_valid, out_op, out_rd, out_a, out_b); end
    checks++; if (pending !== 4'b1001) begin failures++; $display("FAIL bp_pending got=%0b exp=1001", pending); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0h exp=0", out_valid); end
    tick();
    checks++; if (hs_cnt !== 2) begin failures++; $display("FAIL bp_handshakes got=%0d exp=2", hs_cnt); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    in_valid = 1'b1;
    in_instr = 9'b000_10_00_00;
    tick();
    in_valid = 1'b0;
    wb_valid = 1'b1;
    wb_reg   = 2'd2;
    tick();
    wb_valid = 1'b0;
    checks++; if (pending !== 4'b0100 || out_rd !== 2'd2) begin failures++; $display("FAIL sim_set_wins got=%0b/%0h exp=0100/2", pending, out_rd); end
    wb_valid = 1'b1;
    wb_reg   = 2'd0;
    tick();
    checks++; if (pending !== 4'b0100) begin failures++; $display("FAIL sim_wb_nonpending got=%0b exp=0100", pending); end
    wb_reg = 2'd2;
    tick();
    wb_valid = 1'b0;
    checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL sim_wb_clear got=%0b exp=0000", pending); end
  endtask

  task automatic test_store();
    do_reset();
    in_valid = 1'b1;
    in_instr = 9'b000_10_00_00;
    tick();
    in_instr = 9'b000_11_00_00;
    tick();
    in_instr = 9'b110_00_01_10;
    tick();
    in_valid = 1'b0;
    checks++; if (pending !== 4'b1100) begin failures++; $display("FAIL st_pending_pre got=%0b exp=1100", pending); end
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL st_stall got=%0h exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || pending !== 4'b1100) begin failures++; $display("FAIL st_held got=%0h/%0b exp=0/1100", out_valid, pending); end
    wb_valid = 1'b1;
    wb_reg   = 2'd2;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL st_ready got=%0h exp=1", in_ready); end
    tick();
    wb_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_we !== 1'b0 || out_op !== 3'd6) begin failures++; $display("FAIL st_issue got=%0h/%0h/%0h exp=1/0/6", out_valid, out_we, out_op); end
    checks++; if (out_a !== 8'h22 || out_b !== 8'h05 || pending !== 4'b1000) begin failures++; $display("FAIL st_data got=%0h/%0h/%0b exp=22/05/1000", out_a, out_b, pending); end
  endtask

  task automatic test_halt();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 9'b000_00_01_01;
    tick();
    in_instr = 9'h1FF;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || pending !== 4'b0001 || halted !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL halt_queued got=%0h/%0b/%0h/%0h exp=1/0001/0/0", out_valid, pending, halted, in_ready); end
    wb_valid = 1'b1;
    wb_reg   = 2'd0;
    tick();
    wb_valid = 1'b0;
    checks++; if (pending !== 4'b0000 || halted !== 1'b0) begin failures++; $display("FAIL halt_wait_drain got=%0b/%0h exp=0000/0", pending, halted); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL halt_drained got=%0h/%0h exp=0/0", out_valid, halted); end
    tick();
    checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL halt_enter got=%0h/%0h exp=1/0", halted, in_ready); end
    in_valid = 1'b1;
    in_instr = 9'b000_01_00_00;
    repeat (3) begin
      tick();
      checks++; if (in_ready !== 1'b0 || halted !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL halt_sticky got=%0h/%0h/%0h exp=0/1/0", in_ready, halted, out_valid); end
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_reset got=%0h exp=0", halted); end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL halt_restart got=%0h exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1;
    in_instr = {3'd0, 2'd0, 2'd3, 2'd3};
    tick();
    for (int k = 1; k < 4; k++) begin
      in_instr = {3'(k), 2'(k), 2'd3, 2'd3};
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%0h exp=1", k, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_rd !== 2'(k - 1) || out_op !== 3'(k - 1)) begin failures++; $display("FAIL b2b_out%0d got=%0h/%0h/%0h exp=1/%0d/%0d", k, out_valid, out_rd, out_op, k - 1, k - 1); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_rd !== 2'd3) begin failures++; $display("FAIL b2b_last got=%0h/%0h exp=1/3", out_valid, out_rd); end
    tick();
    checks++; if (out_valid !== 1'b0 || pending !== 4'b1111) begin failures++; $display("FAIL b2b_end got=%0h/%0b exp=0/1111", out_valid, pending); end
  endtask

  initial begin
    rf[0] = 8'h11;
    rf[1] = 8'h22;
    rf[2] = 8'h05;
    rf[3] = 8'h07;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 9'd0;
    out_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_reg    = 2'd0;
    #1;
    test_reset();
    test_basic();
    test_raw();
    test_backpressure();
    test_simultaneous();
    test_store();
    test_halt();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
